ctrl_batch_buffer: RTL
======================

Name: ctrl_batch_buffer

Overview:
- Input stage of the control-bounded filter datapath.
- Collects DSR consecutive M-bit control-signal vectors from the ADC modulator interface and packs each group into one M*DSR-bit batch word.
- Presents each batch to the downstream delay/lookahead chain with a valid/ready handshake.
- One staging register plus one holding register; overrun is flagged when the consumer stalls.

Parameters:
- M, 4, control channels (bits per sample).
- DSR, 4, samples per batch (downsampling ratio); legal range 1..64.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  M  one control-signal sample.
- in_valid  in  1  sample strobe; in_data is accepted on every cycle with in_valid=1 (no backpressure to the ADC).
- out_batch  out  M*DSR  packed batch; sample k of the batch occupies bits [k*M +: M], k=0 is the oldest sample.
- out_valid  out  1  holding register contains an unconsumed batch.
- out_ready  in  1  consumer accepts out_batch when out_valid & out_ready.
- overrun  out  1  sticky; set when a completed batch is dropped.

Behaviour:
- Reset (synchronous, active-high, sampled at posedge clk):
  - stage count=0, staging reg=0, out_batch=0, out_valid=0, overrun=0.
  - Reset mid-batch discards the partial batch and any held batch.
- Staging:
  - On in_valid, in_data is written to slot [cnt*M +: M] and cnt increments.
  - cnt is $clog2(DSR)-bit (min 1 bit) and wraps DSR-1 -> 0.
  - With DSR=1, every accepted sample completes a batch.
- Batch completion: the cycle where in_valid=1 and cnt=DSR-1. The completed word is the staging contents with the current sample inserted.
- Transfer rules, evaluated in the completion cycle:
  - Holding empty (out_valid=0), or being consumed in the same cycle (out_valid & out_ready): load holding reg; out_valid=1 next cycle.
  - Holding full and not consumed: drop the new batch, keep the old one, set overrun; cnt still wraps to 0.
- Consumption: out_valid & out_ready with no simultaneous load -> out_valid=0 next cycle. out_batch keeps its last value (not cleared).
- Latency: final sample accepted at cycle t -> out_valid=1 and out_batch valid at t+1.
- Throughput: one batch per DSR input cycles when out_ready is held high.
- out_batch is stable while out_valid=1 and out_ready=0.
- in_valid=0 cycles leave cnt and staging unchanged; gaps are allowed anywhere inside a batch.
- overrun clears only on rst.
- Slots of the staging register are not cleared between batches. Every slot is overwritten before completion, so stale data never leaks into a batch.

Optional Feature:
- Macro: CBF_BATCH_REVERSE_EN.
- Defined:
  - Adds output out_batch_rev (M*DSR): the same batch in time-reversed order, slot k = sample DSR-1-k. Used by the lookback path.
  - Registered in the same holding stage, so it has identical valid/latency to out_batch.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package cbf_pkg holds:
  - function batch_w(M, DSR) returning M*DSR.
  - function cnt_w(DSR) returning max(1, $clog2(DSR)).
  - typedef of the packed ctrl_sample_t used by the datapath stages.
- Sub-module ctrl_batch_stage: staging register, cnt, and the completion strobe. The top level adds the holding register, handshake, overrun, and the optional reverse.

Test Plan:
- M=4, DSR=3, out_ready=1; send 0x1, 0x2, 0x3 on consecutive cycles -> one cycle after the 0x3 sample, out_batch=0x321 and out_valid=1 for one cycle; overrun=0.
- Same configuration, in_valid gaps of 2 idle cycles between samples 0xA, 0xB, 0xC -> out_batch=0xCBA exactly one cycle after 0xC; no early out_valid.
- out_ready=0; send 6 samples 0x1..0x6 -> out_batch stays 0x321 with out_valid=1; overrun=1 the cycle after 0x6; then out_ready=1 for one cycle -> out_valid=0 next cycle.
- Back-to-back consumption: out_ready rises in the same cycle the second batch completes (0x4, 0x5, 0x6) -> no overrun; out_batch=0x654, out_valid stays 1.
- Assert rst after 2 of 3 samples, then send 0x7, 0x8, 0x9 -> out_batch=0x987 (partial batch discarded); all outputs 0 in the cycle after rst.
- With CBF_BATCH_REVERSE_EN, DSR=3, samples 0x1, 0x2, 0x3 -> out_batch_rev=0x123 aligned with out_valid; with DSR=1, every sample gives out_valid and out_batch=in_data one cycle later.

Source files
------------

// File: rtl/ctrl_batch_buffer_pkg.sv
// Shared widths and types for the control-bounded filter input stage.
// Built with or without CBF_BATCH_REVERSE_EN.
package cbf_pkg;

  localparam int CBF_M   = 4;
  localparam int CBF_DSR = 4;

  typedef logic [CBF_M-1:0] ctrl_sample_t;

  function automatic int batch_w(input int m, input int dsr);
    return m * dsr;
  endfunction

  function automatic int cnt_w(input int dsr);
    return (dsr <= 2) ? 1 : $clog2(dsr);
  endfunction

endpackage

// File: rtl/ctrl_batch_buffer_stage.sv
// Staging register and sample counter.
// Raises done_o on the cycle the last sample of a batch arrives.
module ctrl_batch_stage
  import cbf_pkg::*;
#(
  parameter int M   = CBF_M,
  parameter int DSR = CBF_DSR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [M-1:0]     in_data,
  input  logic             in_valid,
  output logic [M*DSR-1:0] batch_o,
  output logic             done_o
);

  localparam int BW = batch_w(M, DSR);
  localparam int CW = cnt_w(DSR);
  localparam logic [CW-1:0] LAST = CW'(DSR - 1);

  logic [BW-1:0] stage_q, stage_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    done_o  = 1'b0;
    if (in_valid) begin
      for (int k = 0; k < DSR; k++) begin
        if (cnt_q == CW'(k)) begin
          stage_d[k*M +: M] = in_data;
        end
      end
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        done_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // The completed word includes the sample arriving this cycle.
  assign batch_o = stage_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/ctrl_batch_buffer.sv
// Batch packer: staging + holding register with valid/ready output.
// CBF_BATCH_REVERSE_EN adds the time-reversed out_batch_rev port.
module ctrl_batch_buffer
  import cbf_pkg::*;
#(
  parameter int M   = CBF_M,
  parameter int DSR = CBF_DSR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [M-1:0]     in_data,
  input  logic             in_valid,
  output logic [M*DSR-1:0] out_batch,
`ifdef CBF_BATCH_REVERSE_EN
  output logic [M*DSR-1:0] out_batch_rev,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  localparam int BW = batch_w(M, DSR);

  logic [BW-1:0] batch_w_s;
  logic          done_s;
  logic          load_s;

  logic [BW-1:0] hold_q, hold_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;

  ctrl_batch_stage #(
    .M   (M),
    .DSR (DSR)
  ) u_stage (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .batch_o  (batch_w_s),
    .done_o   (done_s)
  );

  always_comb begin
    load_s  = done_s && (!valid_q || out_ready);
    hold_d  = hold_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (load_s) begin
      hold_d  = batch_w_s;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    // A completed batch with a stalled holder is dropped.
    if (done_s && !load_s) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_batch = hold_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;

`ifdef CBF_BATCH_REVERSE_EN
  logic [BW-1:0] rev_q, rev_d;

  always_comb begin
    rev_d = rev_q;
    if (load_s) begin
      for (int k = 0; k < DSR; k++) begin
        rev_d[k*M +: M] = batch_w_s[(DSR-1-k)*M +: M];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rev_q <= '0;
    end else begin
      rev_q <= rev_d;
    end
  end

  assign out_batch_rev = rev_q;
`endif

endmodule
